pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 19 +
 rtl/pipe_ctrl_hazard_detect.sv | 16 +
 rtl/pipe_ctrl.sv | 131 +++++++++++++
 tb/tb_pipe_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared core encodings for pipeline control and decode
package pipe_ctrl_pkg;

  // Pipeline control states; encodings are visible on state_out.
  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_FLUSH    = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_SYS_WAIT = 3'd3,
    ST_SYS_EXIT = 3'd4
  } pipe_state_e;

  // Stages that must empty before a memory sync or syscall proceeds.
  localparam int unsigned DEF_PIPELINE_LENGTH = 5;

  // Architectural register index width.
  localparam int unsigned REG_ADDR_W = 5;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// rtl/pipe_ctrl_hazard_detect.sv - combinational load-use hazard comparator
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic                  ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic [REG_ADDR_W-1:0] rsa_i,
  input  logic [REG_ADDR_W-1:0] rsb_i,
  output logic                  load_use_o
);

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign load_use_o = ex_mem_read_i && (ex_rd_i != '0) &&
                      ((ex_rd_i == rsa_i) || (ex_rd_i == rsb_i));

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline hazard, flush, drain and syscall sequencing
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned PIPELINE_LENGTH = DEF_PIPELINE_LENGTH
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  stall_in,
  input  logic                  memsync_in,
  input  logic                  syscall_in,
  input  logic [REG_ADDR_W-1:0] rsa_in,
  input  logic [REG_ADDR_W-1:0] rsb_in,
  input  logic                  ex_mem_read_in,
  input  logic [REG_ADDR_W-1:0] ex_rd_in,
  input  logic                  branch_taken_in,
  input  logic                  mem_busy_in,
  input  logic                  syscall_done_in,
  output logic                  stall_out,
  output logic                  bubble_out,
  output logic                  flush_decode_out,
  output logic                  flush_execute_out,
  output logic                  sysreq_out,
  output logic                  busy_out,
  output logic [2:0]            state_out
);

  localparam int unsigned       CNT_W    = $clog2(PIPELINE_LENGTH) + 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(PIPELINE_LENGTH - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  pipe_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sys_pend_q, sys_pend_d;
  logic             load_use;

  logic stall_raw, bubble_raw, flush_dec_raw, flush_ex_raw, sysreq_raw;

  hazard_detect u_hazard_detect (
    .ex_mem_read_i (ex_mem_read_in),
    .ex_rd_i       (ex_rd_in),
    .rsa_i         (rsa_in),
    .rsb_i         (rsb_in),
    .load_use_o    (load_use)
  );

  // State, drain counter and syscall-pending bit; external stall freezes all three.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      sys_pend_q <= 1'b0;
    end else if (!stall_in) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sys_pend_q <= sys_pend_d;
    end
  end

  // Next-state and control outputs; in RUN, branch beats syscall beats memsync beats load-use.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sys_pend_d    = sys_pend_q;
    stall_raw     = 1'b0;
    bubble_raw    = 1'b0;
    flush_dec_raw = 1'b0;
    flush_ex_raw  = 1'b0;
    sysreq_raw    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (branch_taken_in) begin
          flush_dec_raw = 1'b1;
          flush_ex_raw  = 1'b1;
          state_d       = ST_FLUSH;
        end else if (syscall_in || memsync_in) begin
          state_d    = ST_DRAIN;
          cnt_d      = CNT_LOAD;
          sys_pend_d = syscall_in;
        end else if (load_use) begin
          stall_raw  = 1'b1;
          bubble_raw = 1'b1;
        end
      end
      ST_FLUSH: begin
        flush_dec_raw = 1'b1;
        state_d       = ST_RUN;
      end
      ST_DRAIN: begin
        stall_raw  = 1'b1;
        bubble_raw = 1'b1;
        if ((cnt_q == '0) && !mem_busy_in) begin
          if (sys_pend_q) begin
            state_d = ST_SYS_WAIT;
            // Only pulse on the cycle the transition actually commits.
            sysreq_raw = !stall_in;
          end else begin
            state_d = ST_RUN;
          end
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_SYS_WAIT: begin
        stall_raw  = 1'b1;
        bubble_raw = 1'b1;
        if (syscall_done_in) begin
          state_d    = ST_SYS_EXIT;
          sys_pend_d = 1'b0;
        end
      end
      ST_SYS_EXIT: begin
        flush_dec_raw = 1'b1;
        state_d       = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // All outputs forced low while reset is held, even those decoded from live inputs.
  assign stall_out         = stall_raw     & ~reset_in;
  assign bubble_out        = bubble_raw    & ~reset_in;
  assign flush_decode_out  = flush_dec_raw & ~reset_in;
  assign flush_execute_out = flush_ex_raw  & ~reset_in;
  assign sysreq_out        = sysreq_raw    & ~reset_in;
  assign busy_out          = (state_q != ST_RUN) & ~reset_in;
  assign state_out         = reset_in ? 3'd0 : state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - randomized and directed bench for pipe_ctrl
module tb_pipe_ctrl;

  localparam int PL = 5;

  logic       clk = 1'b0;
  logic       reset_in, stall_in, memsync_in, syscall_in;
  logic [4:0] rsa_in, rsb_in, ex_rd_in;
  logic       ex_mem_read_in, branch_taken_in, mem_busy_in, syscall_done_in;
  logic       stall_out, bubble_out, flush_decode_out, flush_execute_out;
  logic       sysreq_out, busy_out;
  logic [2:0] state_out;

  always #5 clk = ~clk;

  pipe_ctrl #(.PIPELINE_LENGTH(PL)) dut (
    .clk_in            (clk),
    .reset_in          (reset_in),
    .stall_in          (stall_in),
    .memsync_in        (memsync_in),
    .syscall_in        (syscall_in),
    .rsa_in            (rsa_in),
    .rsb_in            (rsb_in),
    .ex_mem_read_in    (ex_mem_read_in),
    .ex_rd_in          (ex_rd_in),
    .branch_taken_in   (branch_taken_in),
    .mem_busy_in       (mem_busy_in),
    .syscall_done_in   (syscall_done_in),
    .stall_out         (stall_out),
    .bubble_out        (bubble_out),
    .flush_decode_out  (flush_decode_out),
    .flush_execute_out (flush_execute_out),
    .sysreq_out        (sysreq_out),
    .busy_out          (busy_out),
    .state_out         (state_out)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: mode number plus count of drain cycles already spent.
  int m_mode;
  int m_drain_spent;
  bit m_sys;

  function automatic bit model_load_use();
    return ex_mem_read_in && (ex_rd_in != 0) && ((ex_rd_in == rsa_in) || (ex_rd_in == rsb_in));
  endfunction

  function automatic bit drain_done();
    return (m_drain_spent >= PL - 1) && !mem_busy_in;
  endfunction

  function automatic logic [8:0] model_out();
    logic st, bu, fd, fe, sr;
    st = 0; bu = 0; fd = 0; fe = 0; sr = 0;
    if (reset_in) return 9'd0;
    case (m_mode)
      0: begin
        if (branch_taken_in) begin fd = 1; fe = 1; end
        else if (syscall_in || memsync_in) ;
        else if (model_load_use()) begin st = 1; bu = 1; end
      end
      1: fd = 1;
      2: begin
        st = 1; bu = 1;
        sr = m_sys && drain_done() && !stall_in;
      end
      3: begin st = 1; bu = 1; end
      4: fd = 1;
      default: ;
    endcase
    return {st, bu, fd, fe, sr, (m_mode != 0), 3'(m_mode)};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_drain_spent = 0; m_sys = 0;
  endtask

  task automatic model_advance();
    if (reset_in) begin
      model_reset();
    end else if (!stall_in) begin
      case (m_mode)
        0: begin
          if (branch_taken_in) m_mode = 1;
          else if (syscall_in || memsync_in) begin
            m_mode = 2; m_drain_spent = 0; m_sys = syscall_in;
          end
        end
        1: m_mode = 0;
        2: begin
          if (drain_done()) m_mode = m_sys ? 3 : 0;
          else m_drain_spent++;
        end
        3: if (syscall_done_in) begin m_mode = 4; m_sys = 0; end
        4: m_mode = 0;
        default: m_mode = 0;
      endcase
    end
  endtask

  // Inputs are set just after a falling edge; compare, clock, advance model.
  task automatic cycle(input string tag);
    #1;
    if (reset_in) model_reset();
    check(tag, {stall_out, bubble_out, flush_decode_out, flush_execute_out,
                sysreq_out, busy_out, state_out}, model_out());
    @(posedge clk);
    model_advance();
    @(negedge clk);
  endtask

  task automatic idle();
    stall_in = 0; memsync_in = 0; syscall_in = 0; rsa_in = 0; rsb_in = 0;
    ex_mem_read_in = 0; ex_rd_in = 0; branch_taken_in = 0; mem_busy_in = 0;
    syscall_done_in = 0;
  endtask

  int cnt_a, cnt_b, cnt_c, sr_idx;
  bit saw_drain;

  initial begin
    idle();
    reset_in = 1;
    model_reset();
    @(negedge clk);
    cycle("reset0");
    cycle("reset1");
    check("reset_state", {29'd0, state_out}, 32'd0);
    reset_in = 0;
    cycle("post_reset");

    // Load-use on rsa, then the same with destination r0.
    ex_mem_read_in = 1; ex_rd_in = 7; rsa_in = 7; rsb_in = 3;
    #1 check("lu_stall_bubble", {30'd0, stall_out, bubble_out}, 32'd3);
    cycle("lu");
    ex_rd_in = 0; rsa_in = 0;
    #1 check("lu_r0_nostall", {30'd0, stall_out, bubble_out}, 32'd0);
    cycle("lu_r0");
    idle();

    // Memory sync with memory idle: five stall cycles then RUN.
    memsync_in = 1;
    cycle("ms_start");
    memsync_in = 0;
    cnt_a = 0;
    for (int i = 0; i < 8; i++) begin
      #1 if (stall_out) cnt_a++;
      cycle("ms_drain");
    end
    check("ms_stall_cycles", cnt_a, 5);
    check("ms_end_state", {29'd0, state_out}, 32'd0);

    // Held drain: memory busy for the first eight drain cycles.
    memsync_in = 1;
    cycle("hold_start");
    memsync_in = 0;
    cnt_a = 0;
    for (int i = 0; i < 14; i++) begin
      mem_busy_in = (i < 8);
      #1 if (stall_out) cnt_a++;
      if (i == 7) check("hold_still_drain", {29'd0, state_out}, 32'd2);
      cycle("hold_drain");
    end
    check("hold_stall_cycles", cnt_a, 9);
    check("hold_end_state", {29'd0, state_out}, 32'd0);
    idle();

    // Syscall: drain, request pulse, wait for done, decode flush, RUN.
    syscall_in = 1; memsync_in = 1;
    cycle("sys_start");
    idle();
    cnt_a = 0; cnt_b = 0; cnt_c = 0; sr_idx = -1;
    for (int i = 0; i < 20; i++) begin
      syscall_done_in = (i == 12);
      #1;
      if (stall_out) cnt_a++;
      if (sysreq_out) begin cnt_b++; sr_idx = i; end
      if (flush_decode_out) cnt_c++;
      cycle("sys_seq");
    end
    check("sys_stall_cycles", cnt_a, 13);
    check("sys_req_pulses", cnt_b, 1);
    check("sys_req_cycle", sr_idx, 4);
    check("sys_exit_flush", cnt_c, 1);
    check("sys_end_state", {29'd0, state_out}, 32'd0);
    idle();

    // Branch together with memsync: both flushes, FLUSH, never DRAIN.
    branch_taken_in = 1; memsync_in = 1;
    #1 check("br_flushes", {30'd0, flush_decode_out, flush_execute_out}, 32'd3);
    cycle("br_start");
    idle();
    check("br_flush_state", {29'd0, state_out}, 32'd1);
    saw_drain = 0;
    for (int i = 0; i < 4; i++) begin
      #1 if (state_out == 3'd2) saw_drain = 1;
      cycle("br_after");
    end
    check("br_no_drain", {31'd0, saw_drain}, 32'd0);

    // Reset during the second drain cycle.
    memsync_in = 1;
    cycle("rst_ms_start");
    memsync_in = 0;
    cycle("rst_drain1");
    reset_in = 1; ex_mem_read_in = 1; ex_rd_in = 4; rsa_in = 4;
    #1 check("rst_outputs_zero", {23'd0, stall_out, bubble_out, flush_decode_out,
             flush_execute_out, sysreq_out, busy_out, state_out}, 32'd0);
    cycle("rst_mid");
    reset_in = 0;
    idle();
    cycle("rst_release");

    // Randomized traffic with occasional stall and reset.
    for (int i = 0; i < 3000; i++) begin
      reset_in        = ($urandom_range(0, 199) == 0);
      stall_in        = ($urandom_range(0, 7) == 0);
      branch_taken_in = ($urandom_range(0, 9) == 0);
      syscall_in      = ($urandom_range(0, 15) == 0);
      memsync_in      = ($urandom_range(0, 11) == 0);
      ex_mem_read_in  = $urandom_range(0, 1);
      ex_rd_in        = 5'($urandom_range(0, 3));
      rsa_in          = 5'($urandom_range(0, 3));
      rsb_in          = 5'($urandom_range(0, 3));
      mem_busy_in     = ($urandom_range(0, 2) == 0);
      syscall_done_in = ($urandom_range(0, 3) == 0);
      cycle("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
